// File: rtl/debug_unit_if.sv
// Debug link bundle: command bytes in, dump bytes out.
// slave = debug_unit side, master = host/transmitter side.
interface debug_unit_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_done;
  logic       tx_start;
  logic [7:0] tx_data;

  modport slave (
    input  rx_valid, rx_data, tx_done,
    output tx_start, tx_data
  );

  modport master (
    output rx_valid, rx_data, tx_done,
    input  tx_start, tx_data
  );
endinterface

// File: rtl/debug_unit.sv
// Pipeline debug controller: run/step/reset/dump commands over a byte link.
// Ports: clk, reset (sync, high), dbg link, pc_enable/pc_reset/busy, 5 debug words.
module debug_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] HALT_INSTR = 32'hFC000000,
  parameter int                    NUM_WORDS  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  debug_unit_if.slave           dbg,
  output logic                  pc_enable,
  output logic                  pc_reset,
  output logic                  busy,
  input  logic [DATA_WIDTH-1:0] pc_addr_in,
  input  logic [DATA_WIDTH-1:0] pc_instr_in,
  input  logic [DATA_WIDTH-1:0] reg_w_data_in,
  input  logic [DATA_WIDTH-1:0] reg_rt_data_in,
  input  logic [DATA_WIDTH-1:0] reg_rs_data_in
);

  localparam int SNAP_W = (NUM_WORDS - 1) * DATA_WIDTH + 32;
  localparam int NBYTES = SNAP_W / 8;
  localparam int IW     = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  localparam logic [7:0] CMD_RUN   = 8'h63;
  localparam logic [7:0] CMD_STEP  = 8'h73;
  localparam logic [7:0] CMD_RST   = 8'h72;
  localparam logic [7:0] CMD_DUMP  = 8'h64;
  localparam logic [7:0] CMD_PAUSE = 8'h70;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_RESET_PIPE,
    S_CAPTURE,
    S_SEND,
    S_WAIT_TX
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [SNAP_W-1:0]   snap_q, snap_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                tx_start_q, tx_start_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                pc_reset_q, pc_reset_d;
  logic                busy_q, busy_d;

  // Byte i of the snapshot, byte 0 being the MSB of pc_addr.
  function automatic logic [7:0] byte_at(
    input logic [SNAP_W-1:0] s,
    input logic [IW-1:0]     i
  );
    logic [SNAP_W-1:0] sh;
    sh = s >> (8 * (NBYTES - 1 - int'(i)));
    return sh[7:0];
  endfunction

  // Same-cycle halt/pause must gate the pipeline, hence combinational.
  always_comb begin
    unique case (state_q)
      S_STEP:  pc_enable = 1'b1;
      S_RUN:   pc_enable = !((pc_instr_in == HALT_INSTR) ||
                             (dbg.rx_valid && dbg.rx_data == CMD_PAUSE));
      default: pc_enable = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    snap_d     = snap_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;

    if (pc_enable && cnt_q != 32'hFFFF_FFFF)
      cnt_d = cnt_q + 32'd1;

    unique case (state_q)
      S_IDLE: begin
        if (dbg.rx_valid) begin
          unique case (1'b1)
            dbg.rx_data == CMD_RUN:  state_d = S_RUN;
            dbg.rx_data == CMD_STEP: state_d = S_STEP;
            dbg.rx_data == CMD_RST:  state_d = S_RESET_PIPE;
            dbg.rx_data == CMD_DUMP: state_d = S_CAPTURE;
            default:                 state_d = S_IDLE;
          endcase
        end
      end
      S_RUN: begin
        if (!pc_enable)
          state_d = S_CAPTURE;
      end
      S_STEP: state_d = S_CAPTURE;
      S_RESET_PIPE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      S_CAPTURE: begin
        snap_d     = {pc_addr_in, pc_instr_in, reg_w_data_in,
                      reg_rt_data_in, reg_rs_data_in, cnt_q};
        idx_d      = '0;
        tx_start_d = 1'b1;
        tx_data_d  = byte_at(snap_d, '0);
        state_d    = S_SEND;
      end
      S_SEND: state_d = S_WAIT_TX;
      S_WAIT_TX: begin
        if (dbg.tx_done) begin
          if (idx_q == LAST) begin
            state_d = S_IDLE;
          end else begin
            idx_d      = idx_q + 1'b1;
            tx_start_d = 1'b1;
            tx_data_d  = byte_at(snap_q, idx_d);
            state_d    = S_SEND;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    pc_reset_d = (state_d == S_RESET_PIPE);
    busy_d     = state_d inside {S_RESET_PIPE, S_CAPTURE,
                                 S_SEND, S_WAIT_TX};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      snap_q     <= '0;
      idx_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      pc_reset_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
      idx_q      <= idx_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      pc_reset_q <= pc_reset_d;
      busy_q     <= busy_d;
    end
  end

  assign dbg.tx_start = tx_start_q;
  assign dbg.tx_data  = tx_data_q;
  assign pc_reset     = pc_reset_q;
  assign busy         = busy_q;

endmodule
